ysyx_23060332_lsu: RTL and testbench

//  Multi-cycle load/store unit directly downstream of the execute stage.

---
 rtl/ysyx_23060332_lsu_if.sv | 14 +
 rtl/ysyx_23060332_lsu.sv | 126 ++++++++++++
 tb/tb_ysyx_23060332_lsu.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060332_lsu_if.sv
// ysyx_23060332_lsu_if: SRAM-style request/response bus between the LSU (master) and memory (slave)
interface ysyx_23060332_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [7:0]  wmask;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;
   modport master(output req_valid, we, addr, wdata, wmask, input req_ready, rsp_valid, rsp_data, rsp_err);
   modport slave(input req_valid, we, addr, wdata, wmask, output req_ready, rsp_valid, rsp_data, rsp_err);
endinterface

// File: rtl/ysyx_23060332_lsu.sv
// ysyx_23060332_lsu: multi-cycle load/store unit driving an SRAM-style bus, with writeback and abort pulses
module ysyx_23060332_lsu #(
   parameter int TIMEOUT = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_wen,
   input  logic [2:0]                 req_func3,
   input  logic [31:0]                req_addr,
   input  logic [31:0]                req_wdata,
   input  logic [4:0]                 req_rd,
   ysyx_23060332_lsu_if.master        bus,
   output logic                       wb_valid,
   output logic                       wb_wen,
   output logic [4:0]                 wb_rd,
   output logic [31:0]                wb_data,
   output logic                       err_valid,
   output logic [1:0]                 err_cause,
   output logic [31:0]                err_addr
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;
   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
   state_t      state;
   logic [7:0]  cnt;
   logic        wen_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [4:0]  rd_q;
   logic        bad_f3;
   logic        misal;
   logic [31:0] st_data;
   logic [3:0]  st_mask;
   logic [31:0] sh;
   logic [31:0] ld_data;
   always_comb begin
      bad_f3  = req_wen ? req_func3 > 3'd2 : (req_func3 == 3'd3 || req_func3 > 3'd5);
      misal   = (req_func3[1:0] == 2'd1 && req_addr[0]) || (req_func3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
      st_data = req_func3[1] ? req_wdata : req_func3[0] ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
      st_mask = req_func3[1] ? 4'b1111 : (req_func3[0] ? 4'b0011 : 4'b0001) << req_addr[1:0];
      sh      = bus.rsp_data >> {addr_q[1:0], 3'b000};
      // funct3[2] marks the unsigned variants, so it gates the sign bit
      ld_data = f3_q[1] ? sh : f3_q[0] ? {{16{sh[15] & ~f3_q[2]}}, sh[15:0]} : {{24{sh[7] & ~f3_q[2]}}, sh[7:0]};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         req_ready     <= 1'b1;
         cnt           <= '0;
         wen_q         <= 1'b0;
         f3_q          <= '0;
         addr_q        <= '0;
         rd_q          <= '0;
         bus.req_valid <= 1'b0;
         bus.we        <= 1'b0;
         bus.addr      <= '0;
         bus.wdata     <= '0;
         bus.wmask     <= '0;
         wb_valid      <= 1'b0;
         wb_wen        <= 1'b0;
         wb_rd         <= '0;
         wb_data       <= '0;
         err_valid     <= 1'b0;
         err_cause     <= '0;
         err_addr      <= '0;
      end else begin
         wb_valid  <= 1'b0;
         err_valid <= 1'b0;
         case (state)
            IDLE: if (req_valid) begin
               req_ready <= 1'b0;
               wen_q     <= req_wen;
               f3_q      <= req_func3;
               addr_q    <= req_addr;
               rd_q      <= req_rd;
               if (bad_f3 || misal) begin
                  state     <= ERR;
                  err_valid <= 1'b1;
                  err_cause <= bad_f3 ? 2'd3 : 2'd0;
                  err_addr  <= req_addr;
               end else begin
                  state         <= REQ;
                  bus.req_valid <= 1'b1;
                  bus.we        <= req_wen;
                  bus.addr      <= {req_addr[31:2], 2'b00};
                  bus.wdata     <= req_wen ? st_data : 32'd0;
                  bus.wmask     <= req_wen ? {4'd0, st_mask} : 8'd0;
               end
            end
            REQ: if (bus.req_ready) begin
               state         <= WAIT;
               bus.req_valid <= 1'b0;
               cnt           <= '0;
            end
            WAIT: if (bus.rsp_valid && bus.rsp_err) begin
               state     <= ERR;
               err_valid <= 1'b1;
               err_cause <= 2'd1;
               err_addr  <= addr_q;
            end else if (bus.rsp_valid) begin
               state    <= DONE;
               wb_valid <= 1'b1;
               wb_wen   <= !wen_q && rd_q != 5'd0;
               wb_rd    <= rd_q;
               wb_data  <= wen_q ? 32'd0 : ld_data;
            end else if (cnt == LAST) begin
               state     <= ERR;
               err_valid <= 1'b1;
               err_cause <= 2'd2;
               err_addr  <= addr_q;
            end else begin
               cnt <= cnt + 8'd1;
            end
            DONE, ERR: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// tb_ysyx_23060332_lsu: table-driven directed checks of the LSU plus multi-cycle corner sequences
module tb_ysyx_23060332_lsu;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wen;
   logic [2:0]  req_func3;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        wb_valid, wb_wen;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        err_valid;
   logic [1:0]  err_cause;
   logic [31:0] err_addr;
   int          errors = 0;
   int          checks = 0;
   int          wb_cnt = 0;
   int          err_cnt = 0;
   int          breq_cnt = 0;

   ysyx_23060332_lsu_if bus();

   ysyx_23060332_lsu #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_func3(req_func3),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .bus(bus),
      .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
      .err_valid(err_valid), .err_cause(err_cause), .err_addr(err_addr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      wb_cnt   += int'(wb_valid);
      err_cnt  += int'(err_valid);
      breq_cnt += int'(bus.req_valid);
   end

   typedef struct {
      logic        wen;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] rsp;
      int          lat;
      logic        err;
      logic [1:0]  cause;
      logic [31:0] ewdata;
      logic [7:0]  emask;
      logic [31:0] edata;
      logic        ewen;
   } vec_t;

   vec_t v[16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic wen, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
      @(negedge clk);
      req_valid = 1'b1;
      req_wen   = wen;
      req_func3 = f3;
      req_addr  = a;
      req_wdata = wd;
      req_rd    = rd;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic run_vec(input int i, input vec_t t);
      int b0, w0, e0;
      b0 = breq_cnt;
      w0 = wb_cnt;
      e0 = err_cnt;
      issue(t.wen, t.f3, t.addr, t.wdata, t.rd);
      if (t.err) begin
         chk($sformatf("v%0d err_valid", i), err_valid, 1);
         chk($sformatf("v%0d err_cause", i), err_cause, t.cause);
         chk($sformatf("v%0d err_addr", i), err_addr, t.addr);
         @(negedge clk);
         chk($sformatf("v%0d err_pulse", i), {err_valid, req_ready}, 2'b01);
         chk($sformatf("v%0d no_bus_req", i), breq_cnt, b0);
         chk($sformatf("v%0d no_wb", i), wb_cnt, w0);
      end else begin
         chk($sformatf("v%0d bus_req", i), {bus.req_valid, bus.we, req_ready}, {1'b1, t.wen, 1'b0});
         chk($sformatf("v%0d bus_addr", i), bus.addr, {t.addr[31:2], 2'b00});
         if (t.wen) chk($sformatf("v%0d bus_store", i), {bus.wdata, bus.wmask}, {t.ewdata, t.emask});
         bus.req_ready = 1'b1;
         @(negedge clk);
         bus.req_ready = 1'b0;
         chk($sformatf("v%0d bus_req_drop", i), bus.req_valid, 0);
         repeat (t.lat - 1) @(negedge clk);
         bus.rsp_valid = 1'b1;
         bus.rsp_data  = t.rsp;
         @(negedge clk);
         bus.rsp_valid = 1'b0;
         chk($sformatf("v%0d wb_valid", i), wb_valid, 1);
         chk($sformatf("v%0d wb_data", i), wb_data, t.edata);
         chk($sformatf("v%0d wb_wen", i), wb_wen, t.ewen);
         if (!t.wen) chk($sformatf("v%0d wb_rd", i), wb_rd, t.rd);
         @(negedge clk);
         chk($sformatf("v%0d wb_pulse", i), {wb_valid, req_ready}, 2'b01);
         chk($sformatf("v%0d counts", i), {32'(wb_cnt - w0), 32'(err_cnt - e0)}, {32'd1, 32'd0});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int w0, e0;
      v[0]  = '{1'b0, 3'd2, 32'h80000004, 32'h0,        5'd5,  32'hDEADBEEF, 2, 1'b0, 2'd0, 32'h0,        8'h00, 32'hDEADBEEF, 1'b1};
      v[1]  = '{1'b0, 3'd0, 32'h80000003, 32'h0,        5'd7,  32'h80FF7F01, 1, 1'b0, 2'd0, 32'h0,        8'h00, 32'hFFFFFF80, 1'b1};
      v[2]  = '{1'b0, 3'd4, 32'h80000003, 32'h0,        5'd8,  32'h80FF7F01, 1, 1'b0, 2'd0, 32'h0,        8'h00, 32'h00000080, 1'b1};
      v[3]  = '{1'b0, 3'd1, 32'h80000002, 32'h0,        5'd9,  32'h80FF7F01, 1, 1'b0, 2'd0, 32'h0,        8'h00, 32'hFFFF80FF, 1'b1};
      v[4]  = '{1'b0, 3'd5, 32'h80000002, 32'h0,        5'd10, 32'h80FF7F01, 1, 1'b0, 2'd0, 32'h0,        8'h00, 32'h000080FF, 1'b1};
      v[5]  = '{1'b0, 3'd0, 32'h80000001, 32'h0,        5'd11, 32'h80FF7F01, 1, 1'b0, 2'd0, 32'h0,        8'h00, 32'h0000007F, 1'b1};
      v[6]  = '{1'b1, 3'd1, 32'h00000010, 32'h1234ABCD, 5'd1,  32'hFFFFFFFF, 1, 1'b0, 2'd0, 32'hABCDABCD, 8'h03, 32'h0,        1'b0};
      v[7]  = '{1'b1, 3'd0, 32'h00000013, 32'h1234ABCD, 5'd2,  32'hFFFFFFFF, 1, 1'b0, 2'd0, 32'hCDCDCDCD, 8'h08, 32'h0,        1'b0};
      v[8]  = '{1'b1, 3'd2, 32'h00000020, 32'hCAFEF00D, 5'd3,  32'hFFFFFFFF, 3, 1'b0, 2'd0, 32'hCAFEF00D, 8'h0F, 32'h0,        1'b0};
      v[9]  = '{1'b1, 3'd1, 32'h00000012, 32'h1234ABCD, 5'd4,  32'hFFFFFFFF, 1, 1'b0, 2'd0, 32'hABCDABCD, 8'h0C, 32'h0,        1'b0};
      v[10] = '{1'b0, 3'd2, 32'h00000002, 32'h0,        5'd5,  32'h0,        1, 1'b1, 2'd0, 32'h0,        8'h00, 32'h0,        1'b0};
      v[11] = '{1'b0, 3'd3, 32'h00000000, 32'h0,        5'd5,  32'h0,        1, 1'b1, 2'd3, 32'h0,        8'h00, 32'h0,        1'b0};
      v[12] = '{1'b1, 3'd4, 32'h00000000, 32'h0,        5'd5,  32'h0,        1, 1'b1, 2'd3, 32'h0,        8'h00, 32'h0,        1'b0};
      v[13] = '{1'b0, 3'd1, 32'h00000041, 32'h0,        5'd5,  32'h0,        1, 1'b1, 2'd0, 32'h0,        8'h00, 32'h0,        1'b0};
      v[14] = '{1'b0, 3'd2, 32'h00000040, 32'h0,        5'd0,  32'h11223344, 1, 1'b0, 2'd0, 32'h0,        8'h00, 32'h11223344, 1'b0};
      v[15] = '{1'b0, 3'd6, 32'h00000008, 32'h0,        5'd5,  32'h0,        1, 1'b1, 2'd3, 32'h0,        8'h00, 32'h0,        1'b0};
      rst = 1'b1;
      req_valid = 1'b0; req_wen = 1'b0; req_func3 = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
      bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = '0; bus.rsp_err = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset ready/valids", {req_ready, bus.req_valid, wb_valid, err_valid}, 4'b1000);
      chk("reset data", {wb_data, err_addr}, 64'd0);
      chk("reset bus", {bus.we, bus.wmask, wb_wen, err_cause}, 12'd0);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) run_vec(i, v[i]);

      // bus error response
      e0 = err_cnt;
      w0 = wb_cnt;
      issue(1'b0, 3'd2, 32'h00000100, 32'h0, 5'd4);
      bus.req_ready = 1'b1;
      @(negedge clk);
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b1;
      bus.rsp_err   = 1'b1;
      @(negedge clk);
      bus.rsp_valid = 1'b0;
      bus.rsp_err   = 1'b0;
      chk("buserr pulse", {err_valid, wb_valid}, 2'b10);
      chk("buserr cause", err_cause, 2'd1);
      chk("buserr addr", err_addr, 32'h100);
      @(negedge clk);
      chk("buserr counts", {32'(err_cnt - e0), 32'(wb_cnt - w0)}, {32'd1, 32'd0});

      // timeout after exactly four WAIT cycles
      issue(1'b0, 3'd2, 32'h00000200, 32'h0, 5'd6);
      bus.req_ready = 1'b1;
      @(negedge clk);
      bus.req_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("timeout not early", err_valid, 0);
      @(negedge clk);
      chk("timeout fires", {err_valid, err_cause}, {1'b1, 2'd2});
      chk("timeout addr", err_addr, 32'h200);
      @(negedge clk);

      // request stalled for five cycles, with a stray response while in REQ
      issue(1'b1, 3'd2, 32'h00000030, 32'h55AA55AA, 5'd1);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("stall%0d ctl", k), {bus.req_valid, bus.we, bus.wmask}, {2'b11, 8'h0F});
         chk($sformatf("stall%0d data", k), {bus.addr, bus.wdata}, {32'h30, 32'h55AA55AA});
         bus.rsp_valid = (k == 1);
         @(negedge clk);
      end
      bus.rsp_valid = 1'b0;
      bus.req_ready = 1'b1;
      @(negedge clk);
      bus.req_ready = 1'b0;
      chk("stall wait", {bus.req_valid, wb_valid}, 2'b00);
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = 32'hFFFFFFFF;
      @(negedge clk);
      bus.rsp_valid = 1'b0;
      chk("stall done", {wb_valid, wb_wen, wb_data}, {2'b10, 32'd0});
      @(negedge clk);

      // reset while waiting drops the op; a late response is ignored
      w0 = wb_cnt;
      e0 = err_cnt;
      issue(1'b0, 3'd2, 32'h00000300, 32'h0, 5'd3);
      bus.req_ready = 1'b1;
      @(negedge clk);
      bus.req_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst idle", {req_ready, bus.req_valid}, 2'b10);
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = 32'h1;
      @(negedge clk);
      bus.rsp_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst no pulses", {32'(wb_cnt - w0), 32'(err_cnt - e0)}, 64'd0);
      run_vec(100, v[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
